eth_mac_tx_framer: RTL and testbench
====================================

# eth_mac_tx_framer

Transmit framing engine of the Ethernet MAC. It consumes byte-wide AXI-Stream packets from the TX FIFO and emits complete Ethernet frames as a GMII-style byte stream to the RGMII transmit stage: preamble, SFD, payload, padding, FCS, then the inter-frame gap. A downstream clock-enable paces byte output, so one 125 MHz clock serves 10/100/1000 link speeds.

## Interface
- MIN_PAYLOAD_BYTES, 60, minimum frame length before FCS; shorter frames are padded up to it.
- IFG_BYTES, 12, inter-frame gap length in byte slots.
- PREAMBLE_BYTES, 7, count of 0x55 bytes before the SFD.
- clk_125  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- s_tx_axis_tdata  input  8  payload byte from the TX FIFO.
- s_tx_axis_tvalid  input  1  FIFO holds valid data.
- s_tx_axis_tlast  input  1  final payload byte of the packet.
- s_tx_axis_trdy  output  1  framer accepts a byte this cycle.
- tx_ce  input  1  byte-slot enable from the RGMII stage; tied high at 1 Gb/s, one pulse per byte slot at 10/100.
- gmii_txd  output  8  frame byte.
- gmii_tx_en  output  1  frame byte valid.
- gmii_tx_er  output  1  transmit error (underrun).
- tx_frame_done  output  1  one-cycle pulse after the last FCS byte.
- tx_underrun  output  1  one-cycle pulse when an underrun is detected.

## Operation
- States: IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, DRAIN, IFG. The state machine, byte counter, and CRC advance only on cycles with tx_ce=1, except in DRAIN.
- IDLE: when tvalid=1 and tx_ce=1, drive txd=0x55 and tx_en=1, set the byte counter to 1, and go to PREAMBLE.
- PREAMBLE: emit 0x55 until PREAMBLE_BYTES bytes have been sent, then go to SFD. SFD emits 0xD5 and then goes to PAYLOAD.
- PAYLOAD: s_tx_axis_trdy = tx_ce. On a handshake, drive txd=tdata, increment the payload count, and update the CRC.
  - If tlast is set and count+1 < MIN_PAYLOAD_BYTES, go to PAD.
  - Otherwise, on tlast, go to FCS.
- Underrun: if tvalid=0 in PAYLOAD with tx_ce=1, drive txd=0x00, tx_en=1, tx_er=1 for that one slot and pulse tx_underrun. The next slot has tx_en=0 and the FSM goes to DRAIN.
- DRAIN: tx_en=0 and trdy=1 on every cycle regardless of tx_ce. Bytes are discarded until a tlast handshake, then the FSM goes to IFG. No FCS is sent.
- PAD: emit 0x00 and update the CRC until the payload count reaches MIN_PAYLOAD_BYTES.
- FCS: emit ~crc in four bytes, bits [7:0] first, then go to IFG and pulse tx_frame_done on the cycle the last byte is registered.
- CRC32: reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF at IDLE exit, computed over payload and pad only.
- IFG: tx_en=0 for IFG_BYTES enabled slots, then IDLE. Any tvalid during IFG is held off.
- trdy is 0 in every state except PAYLOAD and DRAIN.

## Timing
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - CRC 0xFFFFFFFF;
  - counters 0.
- Reset asserted mid-frame aborts immediately: tx_en falls asynchronously and no FCS is sent.
- All GMII outputs are registered. The following cycle numbers assume tx_ce=1 throughout:
  - tvalid sampled at edge 0 → 0x55 visible after edges 0..6;
  - 0xD5 after edge 7;
  - trdy high during the cycle after edge 7;
  - payload byte 0 on gmii_txd after edge 8.
- With tx_ce gated, each byte holds on gmii_txd until the next tx_ce cycle.
- Minimum frame on the wire is 8 + 60 + 4 = 72 byte slots. The minimum gap between frames is IFG_BYTES slots with tx_en=0.
- Byte counter is 11 bits and saturates at 2047. Frames longer than 2047 bytes are still sent, but the saturated counter no longer drives any padding decision.

## Configuration
- ETH_TX_PAD_EN defined: short frames are padded to MIN_PAYLOAD_BYTES as described in Operation.
- ETH_TX_PAD_EN undefined: the PAD state is not generated; tlast always goes to FCS, so runt frames are transmitted as-is.

## Structure
- Shared package eth_mac_pkg holds:
  - tx_state_t enum;
  - ETH_PREAMBLE_BYTE (0x55);
  - ETH_SFD_BYTE (0xD5);
  - CRC32_POLY (0xEDB88320);
  - CRC32_INIT (0xFFFFFFFF);
  - CRC32_RESIDUE (0xDEBB20E3).
- Sub-module eth_crc32_byte: a combinational next-CRC function of the current CRC and one data byte; the framer holds the CRC register.

## Test plan
- 60-byte packet 0x00..0x3B, tx_ce=1 → 7×0x55, 0xD5, 60 payload bytes, 4 FCS bytes; CRC over payload+FCS gives residue 0xDEBB20E3; tx_frame_done pulses once; tx_en low for 12 cycles afterwards.
- 1-byte packet 0xAB → payload 0xAB followed by 59×0x00, FCS matching the reference model; with ETH_TX_PAD_EN undefined, 1 byte plus 4-byte FCS only.
- tvalid dropped after byte 10 of 100 → one slot with tx_er=1 and txd=0x00, tx_underrun pulses, remaining bytes drained until tlast, no FCS, then the IFG.
- tx_ce pulsing 1 in 10 cycles with a 64-byte packet → identical byte sequence to the 1 Gb/s case, each byte held for 10 cycles, trdy high only on tx_ce cycles.
- Two back-to-back 64-byte packets with tvalid held high → the second preamble starts exactly 12 enabled slots after the first FCS ends.
- reset_n pulsed low during payload byte 30 → all outputs 0 immediately; the next packet after release is framed correctly from the preamble.

Source files
------------

// File: rtl/eth_mac_pkg.sv
// Shared constants and types for the Ethernet MAC transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eth_mac_pkg;

    localparam int unsigned MIN_PAYLOAD_BYTES = 60;
    localparam int unsigned IFG_BYTES         = 12;
    localparam int unsigned PREAMBLE_BYTES    = 7;

    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC32_POLY        = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT        = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE     = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_PREAMBLE,
        TX_SFD,
        TX_PAYLOAD,
        TX_PAD,
        TX_FCS,
        TX_DRAIN,
        TX_IFG
    } tx_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// Next-state CRC32 (reflected) for one data byte, LSB first.
// Latency: combinational.
// Backpressure: none; caller decides when to commit the result.
module eth_crc32_byte
    import eth_mac_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    // Fold the byte into the low bits, then shift eight times through the polynomial.
    always_comb begin
        logic [31:0] c;
        c = crc_i ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/eth_mac_tx_framer.sv
// Frames AXI-Stream payload into GMII bytes: preamble, SFD, payload, pad, FCS, IFG. Padding enabled by ETH_TX_PAD_EN.
// Latency: first 0x55 one cycle after tvalid is seen on a tx_ce cycle; every byte is registered.
// Backpressure: trdy follows tx_ce in PAYLOAD, is always high in DRAIN, low otherwise; output holds between tx_ce slots.
module eth_mac_tx_framer
    import eth_mac_pkg::*;
(
    input  logic       clk_125,
    input  logic       reset_n,
    input  logic [7:0] s_tx_axis_tdata,
    input  logic       s_tx_axis_tvalid,
    input  logic       s_tx_axis_tlast,
    output logic       s_tx_axis_trdy,
    input  logic       tx_ce,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       tx_frame_done,
    output logic       tx_underrun
);

    localparam logic [10:0] CNT_MAX  = '1;
    localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_BYTES);
    localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES);
`ifdef ETH_TX_PAD_EN
    localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD_BYTES);
`endif

    tx_state_t   state_q, state_d;
    logic [10:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0] crc_q, crc_d, crc_next, fcs;
    logic [7:0]  txd_q, txd_d, crc_byte_in;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic        done_q, done_d;
    logic        underrun_q, underrun_d;

    // Pad bytes are zeros; only PAYLOAD feeds real data into the CRC.
    assign crc_byte_in = (state_q == TX_PAYLOAD) ? s_tx_axis_tdata : 8'h00;
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 11'd1;
    assign fcs         = ~crc_q;

    eth_crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (crc_byte_in),
        .crc_o  (crc_next)
    );

    assign s_tx_axis_trdy = ((state_q == TX_PAYLOAD) && tx_ce) || (state_q == TX_DRAIN);
    assign gmii_txd       = txd_q;
    assign gmii_tx_en     = tx_en_q;
    assign gmii_tx_er     = tx_er_q;
    assign tx_frame_done  = done_q;
    assign tx_underrun    = underrun_q;

    // Next-state and next-output decode; DRAIN runs every cycle, all else only on tx_ce slots.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        txd_d      = txd_q;
        tx_en_d    = tx_en_q;
        tx_er_d    = tx_er_q;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        if (state_q == TX_DRAIN) begin
            txd_d   = 8'h00;
            tx_en_d = 1'b0;
            tx_er_d = 1'b0;
            if (s_tx_axis_tvalid && s_tx_axis_tlast) begin
                state_d = TX_IFG;
                cnt_d   = '0;
            end
        end else if (tx_ce) begin
            txd_d   = 8'h00;
            tx_en_d = 1'b1;
            tx_er_d = 1'b0;
            case (state_q)
                TX_IDLE: begin
                    if (s_tx_axis_tvalid) begin
                        txd_d   = ETH_PREAMBLE_BYTE;
                        cnt_d   = 11'd1;
                        crc_d   = CRC32_INIT;
                        state_d = TX_PREAMBLE;
                    end else begin
                        tx_en_d = 1'b0;
                    end
                end
                TX_PREAMBLE: begin
                    txd_d = ETH_PREAMBLE_BYTE;
                    cnt_d = cnt_inc;
                    if (cnt_inc == PRE_LAST) state_d = TX_SFD;
                end
                TX_SFD: begin
                    txd_d   = ETH_SFD_BYTE;
                    cnt_d   = '0;
                    state_d = TX_PAYLOAD;
                end
                TX_PAYLOAD: begin
                    if (s_tx_axis_tvalid) begin
                        txd_d = s_tx_axis_tdata;
                        cnt_d = cnt_inc;
                        crc_d = crc_next;
                        if (s_tx_axis_tlast) begin
`ifdef ETH_TX_PAD_EN
                            if (cnt_inc < MIN_LEN) begin
                                state_d = TX_PAD;
                            end else begin
                                state_d = TX_FCS;
                                cnt_d   = '0;
                            end
`else
                            state_d = TX_FCS;
                            cnt_d   = '0;
`endif
                        end
                    end else begin
                        // FIFO ran dry mid-frame: poison this slot, then discard the rest.
                        tx_er_d    = 1'b1;
                        underrun_d = 1'b1;
                        state_d    = TX_DRAIN;
                    end
                end
`ifdef ETH_TX_PAD_EN
                TX_PAD: begin
                    cnt_d = cnt_inc;
                    crc_d = crc_next;
                    if (cnt_inc == MIN_LEN) begin
                        state_d = TX_FCS;
                        cnt_d   = '0;
                    end
                end
`endif
                TX_FCS: begin
                    txd_d = fcs[{cnt_q[1:0], 3'b000} +: 8];
                    cnt_d = cnt_q + 11'd1;
                    if (cnt_q[1:0] == 2'd3) begin
                        state_d = TX_IFG;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
                TX_IFG: begin
                    tx_en_d = 1'b0;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == IFG_LAST) begin
                        state_d = TX_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    tx_en_d = 1'b0;
                    state_d = TX_IDLE;
                end
            endcase
        end
    end

    // Registered FSM, counters, CRC and outputs; reset aborts any frame immediately.
    always_ff @(posedge clk_125 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= TX_IDLE;
            cnt_q      <= '0;
            crc_q      <= CRC32_INIT;
            txd_q      <= '0;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            txd_q      <= txd_d;
            tx_en_q    <= tx_en_d;
            tx_er_q    <= tx_er_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_eth_mac_tx_framer.sv
// Self-checking bench for eth_mac_tx_framer against a byte-level frame model.
// Covers reset, framing at 1G and 10/100 pacing, underrun, back-to-back IFG and mid-frame reset.
// Honors ETH_TX_PAD_EN when building expected frames.
`timescale 1ns/1ps
module tb_eth_mac_tx_framer;

    logic       clk_125 = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] s_tx_axis_tdata = 8'h00;
    logic       s_tx_axis_tvalid = 1'b0;
    logic       s_tx_axis_tlast = 1'b0;
    logic       s_tx_axis_trdy;
    logic       tx_ce = 1'b0;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       tx_frame_done;
    logic       tx_underrun;

    eth_mac_tx_framer dut (
        .clk_125          (clk_125),
        .reset_n          (reset_n),
        .s_tx_axis_tdata  (s_tx_axis_tdata),
        .s_tx_axis_tvalid (s_tx_axis_tvalid),
        .s_tx_axis_tlast  (s_tx_axis_tlast),
        .s_tx_axis_trdy   (s_tx_axis_trdy),
        .tx_ce            (tx_ce),
        .gmii_txd         (gmii_txd),
        .gmii_tx_en       (gmii_tx_en),
        .gmii_tx_er       (gmii_tx_er),
        .tx_frame_done    (tx_frame_done),
        .tx_underrun      (tx_underrun)
    );

    always #4 clk_125 = ~clk_125;

    int checks = 0;
    int errors = 0;
    int phase = 0;
    int trdy_bad = 0;

    logic [7:0] src_dat[$];
    logic       src_last[$];
    logic [7:0] exp_q[$];

    // Wire monitor: one byte captured per enabled slot.
    logic       ce_prev = 1'b0;
    logic       en_last = 1'b0;
    logic [7:0] got_q[$];
    int         gaps[$];
    int         gap_run = 0;
    int         en_cycles = 0, er_cycles = 0, done_cnt = 0, ur_cnt = 0;

    always @(posedge clk_125) ce_prev <= tx_ce;

    always @(negedge clk_125) begin
        if (reset_n) begin
            if (ce_prev) begin
                if (gmii_tx_en) begin
                    got_q.push_back(gmii_txd);
                    if (!en_last) gaps.push_back(gap_run);
                    gap_run <= 0;
                end else begin
                    gap_run <= gap_run + 1;
                end
                en_last <= gmii_tx_en;
            end
            if (gmii_tx_en)    en_cycles <= en_cycles + 1;
            if (gmii_tx_er)    er_cycles <= er_cycles + 1;
            if (tx_frame_done) done_cnt  <= done_cnt + 1;
            if (tx_underrun)   ur_cnt    <= ur_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Queue a packet on the source and append its expected wire image to exp_q.
    // mode 0: random bytes, 1: incrementing, 2: constant 0xAB.
    task automatic add_packet(input int len, input int mode);
        logic [7:0]  pl[$];
        logic [7:0]  b;
        logic [31:0] c;
        logic [31:0] fcs;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            if (mode == 0)      b = 8'($urandom_range(0, 255));
            else if (mode == 1) b = 8'(i);
            else                b = 8'hAB;
            pl.push_back(b);
            src_dat.push_back(b);
            src_last.push_back(i == len - 1);
        end
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
`ifdef ETH_TX_PAD_EN
        while (pl.size() < 60) pl.push_back(8'h00);
`endif
        foreach (pl[i]) begin
            exp_q.push_back(pl[i]);
            c = crc_step(c, pl[i]);
        end
        fcs = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
    endtask

    task automatic idle(input int n, input int period);
        repeat (n) begin
            @(negedge clk_125);
            tx_ce = (phase % period == 0);
            phase++;
            s_tx_axis_tvalid = 1'b0;
            s_tx_axis_tlast  = 1'b0;
        end
        #1;
    endtask

    // Feed src queues with the given tx_ce period; optionally drop tvalid once at
    // byte index drop_at, or pulse reset once byte reset_at is on the wire.
    task automatic run_source(input int period, input int drop_at, input int reset_at);
        int idx = 0;
        int guard = 0;
        bit dropped = 0;
        bit aborted = 0;
        bit hs;
        while (idx < src_dat.size() && guard < 20000 && !aborted) begin
            @(negedge clk_125);
            guard++;
            if (reset_at >= 0 && idx == reset_at + 1) begin
                s_tx_axis_tvalid = 1'b0;
                reset_n = 1'b0;
                #1;
                check("rst_mid_tx_en", 32'(gmii_tx_en), 0);
                check("rst_mid_txd", 32'(gmii_txd), 0);
                check("rst_mid_tx_er", 32'(gmii_tx_er), 0);
                check("rst_mid_trdy", 32'(s_tx_axis_trdy), 0);
                @(negedge clk_125);
                reset_n = 1'b1;
                aborted = 1;
            end else begin
                tx_ce = (phase % period == 0);
                phase++;
                if (idx == drop_at && !dropped) begin
                    s_tx_axis_tvalid = 1'b0;
                    dropped = tx_ce;
                end else begin
                    s_tx_axis_tvalid = 1'b1;
                    s_tx_axis_tdata  = src_dat[idx];
                    s_tx_axis_tlast  = src_last[idx];
                end
                #1;
                hs = s_tx_axis_tvalid && s_tx_axis_trdy;
                if (s_tx_axis_trdy && !tx_ce) trdy_bad++;
                @(posedge clk_125);
                if (hs) idx++;
            end
        end
        if (!aborted) check("src_consumed", 32'(idx), 32'(src_dat.size()));
        src_dat.delete();
        src_last.delete();
    endtask

    task automatic check_frame(input string tag, input int start);
        int n;
        int bad;
        n = got_q.size() - start;
        bad = -1;
        check({tag, "_len"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++)
            if (bad < 0 && got_q[start + i] !== exp_q[i]) bad = i;
        check({tag, "_first_bad_byte"}, 32'(bad), 32'hFFFFFFFF);
    endtask

    task automatic check_residue(input string tag, input int start);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = start + 8; i < got_q.size(); i++) c = crc_step(c, got_q[i]);
        check(tag, c, 32'hDEBB20E3);
    endtask

    initial begin
        int s0, d0, e0, r0, u0, g0;

        // Reset state
        repeat (3) @(negedge clk_125);
        #1;
        check("reset_txd", 32'(gmii_txd), 0);
        check("reset_tx_en", 32'(gmii_tx_en), 0);
        check("reset_tx_er", 32'(gmii_tx_er), 0);
        check("reset_done", 32'(tx_frame_done), 0);
        check("reset_underrun", 32'(tx_underrun), 0);
        check("reset_trdy", 32'(s_tx_axis_trdy), 0);
        reset_n = 1'b1;
        idle(5, 1);

        // 60-byte incrementing packet at 1G
        exp_q.delete();
        s0 = got_q.size(); d0 = done_cnt; e0 = en_cycles; r0 = er_cycles;
        add_packet(60, 1);
        run_source(1, -1, -1);
        idle(20, 1);
        check_frame("p60", s0);
        check_residue("p60_residue", s0);
        check("p60_done", 32'(done_cnt - d0), 1);
        check("p60_en_cycles", 32'(en_cycles - e0), 72);
        check("p60_er", 32'(er_cycles - r0), 0);
        check("p60_idle_en", 32'(gmii_tx_en), 0);

        // 1-byte runt
        exp_q.delete();
        s0 = got_q.size();
        add_packet(1, 2);
        run_source(1, -1, -1);
        idle(20, 1);
        check_frame("p1", s0);
        check_residue("p1_residue", s0);
`ifdef ETH_TX_PAD_EN
        check("p1_wire_len", 32'(got_q.size() - s0), 72);
`else
        check("p1_wire_len", 32'(got_q.size() - s0), 13);
`endif

        // Random lengths
        for (int t = 0; t < 3; t++) begin
            exp_q.delete();
            s0 = got_q.size();
            add_packet(int'($urandom_range(1, 80)), 0);
            run_source(1, -1, -1);
            idle(20, 1);
            check_frame("rand", s0);
            check_residue("rand_residue", s0);
        end

        // Underrun after 10 of 100 bytes
        exp_q.delete();
        s0 = got_q.size(); d0 = done_cnt; r0 = er_cycles; u0 = ur_cnt;
        add_packet(100, 0);
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 10; i++) exp_q.push_back(src_dat[i]);
        exp_q.push_back(8'h00);
        run_source(1, 10, -1);
        idle(20, 1);
        check_frame("urun", s0);
        check("urun_er_slots", 32'(er_cycles - r0), 1);
        check("urun_pulse", 32'(ur_cnt - u0), 1);
        check("urun_no_done", 32'(done_cnt - d0), 0);
        check("urun_trdy_after", 32'(s_tx_axis_trdy), 0);
        exp_q.delete();
        s0 = got_q.size();
        add_packet(5, 0);
        run_source(1, -1, -1);
        idle(20, 1);
        check_frame("post_urun", s0);

        // 10/100 pacing: tx_ce one cycle in ten
        exp_q.delete();
        s0 = got_q.size(); d0 = done_cnt; e0 = en_cycles;
        trdy_bad = 0;
        add_packet(64, 0);
        run_source(10, -1, -1);
        idle(250, 10);
        check_frame("ce10", s0);
        check("ce10_en_cycles", 32'(en_cycles - e0), 760);
        check("ce10_trdy_off_ce", 32'(trdy_bad), 0);
        check("ce10_done", 32'(done_cnt - d0), 1);

        // Back-to-back with tvalid held high
        exp_q.delete();
        s0 = got_q.size(); d0 = done_cnt; g0 = gaps.size();
        add_packet(64, 0);
        add_packet(64, 0);
        run_source(1, -1, -1);
        idle(30, 1);
        check_frame("b2b", s0);
        check("b2b_frames", 32'(gaps.size() - g0), 2);
        check("b2b_gap", 32'(gaps[g0 + 1]), 12);
        check("b2b_done", 32'(done_cnt - d0), 2);

        // Reset during payload byte 30, then a clean frame
        add_packet(64, 0);
        run_source(1, -1, 30);
        idle(5, 1);
        exp_q.delete();
        s0 = got_q.size();
        add_packet(64, 0);
        run_source(1, -1, -1);
        idle(20, 1);
        check_frame("post_rst", s0);
        check_residue("post_rst_residue", s0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
